ram_initiator: RTL and testbench

- Master-side sequencer for the single-port RAM valid/ready interface (Wr_Rd, ADDR, WDATA, RDATA, ready).
- Accepts one host command at a time and drives the matching RAM transaction.
- Waits for ram_ready, then returns read data and status on a one-cycle response pulse.
- Bounds stalled RAM accesses with a timeout counter.

---
 rtl/ram_initiator.sv | 148 ++++++++++++++
 tb/tb_ram_initiator.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_initiator.sv
// Host-command to single-port RAM sequencer with a bounded wait on ram_ready.
// Optional write read-back check enabled by defining RAM_INITIATOR_READBACK_VERIFY_EN.
`timescale 1ns/1ps
module ram_initiator #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ram_valid,
  output logic              ram_wr_rd,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

`ifdef RAM_INITIATOR_READBACK_VERIFY_EN
  // S_GAP keeps ram_valid low for one cycle between the write and its read-back.
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_GAP, S_VERIFY} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
`endif

  state_t state, state_next;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic waiting, done, timed_out;

  // Saturating increment: the counter never wraps, even with the timeout disabled.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  always_comb begin
    waiting = (state == S_REQ);
`ifdef RAM_INITIATOR_READBACK_VERIFY_EN
    waiting = waiting || (state == S_VERIFY);
`endif
    done      = waiting && ram_ready;
    timed_out = waiting && !ram_ready && TO_EN && (cnt_inc == CNT_LIM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (cmd_valid) state_next = S_REQ;
      S_REQ: begin
        if (done) begin
`ifdef RAM_INITIATOR_READBACK_VERIFY_EN
          state_next = ram_wr_rd ? S_GAP : S_RESP;
`else
          state_next = S_RESP;
`endif
        end else if (timed_out) begin
          state_next = S_RESP;
        end
      end
`ifdef RAM_INITIATOR_READBACK_VERIFY_EN
      S_GAP:    state_next = S_VERIFY;
      S_VERIFY: if (done || timed_out) state_next = S_RESP;
`endif
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == S_IDLE);
    rsp_valid = (state == S_RESP);
    ram_valid = waiting;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_wr_rd <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            ram_wr_rd <= cmd_wr;
            ram_addr  <= cmd_addr;
            ram_wdata <= cmd_wdata;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cnt       <= '0;
          end
        end
        S_REQ: begin
          if (done) begin
            cnt       <= '0;
            rsp_rdata <= ram_wr_rd ? '0 : ram_rdata;
`ifdef RAM_INITIATOR_READBACK_VERIFY_EN
            ram_wr_rd <= 1'b0;
`endif
          end else begin
            cnt <= cnt_inc;
            if (timed_out) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
`ifdef RAM_INITIATOR_READBACK_VERIFY_EN
        S_VERIFY: begin
          if (done) begin
            rsp_rdata <= ram_rdata;
            rsp_err   <= (ram_rdata != ram_wdata);
          end else begin
            cnt <= cnt_inc;
            if (timed_out) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
`endif
        S_RESP: begin
          rsp_err <= 1'b0;
          cnt     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_initiator.sv
// Self-checking bench for ram_initiator: directed table, hand-written corner sequences
// and randomized commands against a memory-level reference model.
`timescale 1ns/1ps
module tb_ram_initiator;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int TMO    = 16;
`ifdef RAM_INITIATOR_READBACK_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_wr = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic cmd_ready, rsp_valid, rsp_err, ram_valid, ram_wr_rd;
  logic [DATA_W-1:0] rsp_rdata, ram_wdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic ram_ready = 1'b0;

  always #5 clk = ~clk;

  ram_initiator #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_valid(ram_valid), .ram_wr_rd(ram_wr_rd), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM environment: ready after ready_delay valid cycles; writes stored XOR corrupt.
  logic [DATA_W-1:0] ram_mem [16];
  int ready_delay = 0;
  int wait_cnt = 0;
  logic [DATA_W-1:0] corrupt = '0;
  bit noise_en = 1'b0;

  always @(negedge clk) begin
    if (rst || !ram_valid) begin
      wait_cnt  = 0;
      ram_ready = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      ram_rdata = noise_en ? DATA_W'($urandom) : '0;
    end else if (wait_cnt >= ready_delay) begin
      ram_ready = 1'b1;
      if (ram_wr_rd) ram_mem[ram_addr] = ram_wdata ^ corrupt;
      else           ram_rdata = ram_mem[ram_addr];
    end else begin
      ram_ready = 1'b0;
      wait_cnt++;
    end
  end

  // Bus monitor: request stability, burst length, transfer and rise counts.
  int run_len = 0, last_len = 0, stab_err = 0, xfers = 0, rises = 0;
  logic prev_valid = 1'b0;
  logic [ADDR_W+DATA_W:0] prev_cmd = '0;

  always @(negedge clk) begin
    #1;
    if (ram_valid) begin
      if (!prev_valid) rises++;
      else if ({ram_wr_rd, ram_addr, ram_wdata} != prev_cmd) stab_err++;
      if (ram_ready) xfers++;
      run_len++;
    end else if (run_len > 0) begin
      last_len = run_len;
      run_len  = 0;
    end
    prev_valid = ram_valid;
    prev_cmd   = {ram_wr_rd, ram_addr, ram_wdata};
  end

  // Scoreboard: every response pops one expected {err, rdata}.
  logic [DATA_W:0] exp_q[$];
  logic prev_rsp = 1'b0;

  always @(negedge clk) begin
    logic [DATA_W:0] e;
    if (rsp_valid) begin
      check("rsp_one_cycle", prev_rsp, 0);
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", rsp_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e[DATA_W-1:0]);
        check("rsp_err", rsp_err, e[DATA_W]);
      end
    end
    prev_rsp = rsp_valid;
  end

  // Reference model in terms of memory contents and the timeout rule.
  logic [DATA_W-1:0] ref_mem [16];

  task automatic ref_op(input bit wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                        input int d, input logic [DATA_W-1:0] corr,
                        output logic [DATA_W-1:0] rdata, output bit err);
    if (d >= TMO) begin
      rdata = '0;
      err   = 1'b1;
    end else if (!wr) begin
      rdata = ref_mem[addr];
      err   = 1'b0;
    end else begin
      ref_mem[addr] = data ^ corr;
      rdata = VFY ? (data ^ corr) : '0;
      err   = VFY && (corr != '0);
    end
  endtask

  function automatic int exp_latency(input bit wr, input int d);
    if (d >= TMO) return TMO + 1;
    if (VFY && wr) return 2 * d + 4;
    return d + 2;
  endfunction

  task automatic do_cmd(input bit wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                        input int d, input logic [DATA_W-1:0] corr,
                        input logic [DATA_W-1:0] e_rdata, input bit e_err, input bit keep);
    int guard, lat;
    ready_delay = d;
    corrupt     = corr;
    exp_q.push_back({e_err, e_rdata});
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      check("cmd_accept", cmd_ready, 1);
      cmd_valid = 1'b0;
      exp_q.delete();
      return;
    end
    @(posedge clk);
    #1;
    if (!keep) cmd_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 200);
    check("rsp_latency", lat, exp_latency(wr, d));
    if (!rsp_valid) exp_q.delete();
    if (!keep) begin
      @(negedge clk);
      check("cmd_ready_after_rsp", cmd_ready, 1);
      check("ram_valid_len", last_len, (d >= TMO) ? TMO : d + 1);
    end
  endtask

  typedef struct {
    bit              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int              delay;
    logic [DATA_W-1:0] corr;
    logic [DATA_W-1:0] e_rdata;
    bit              e_err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [DATA_W-1:0] rd;
    bit er;
    int x0, r0, seen;

    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end

    vecs.push_back('{1'b1, 4'd3,  8'hA5, 0,  8'h00, VFY ? 8'hA5 : 8'h00, 1'b0});
    vecs.push_back('{1'b0, 4'd3,  8'h00, 0,  8'h00, 8'hA5, 1'b0});
    vecs.push_back('{1'b1, 4'd15, 8'h3C, 0,  8'h00, VFY ? 8'h3C : 8'h00, 1'b0});
    vecs.push_back('{1'b0, 4'd15, 8'h00, 5,  8'h00, 8'h3C, 1'b0});
    vecs.push_back('{1'b0, 4'd3,  8'h00, 15, 8'h00, 8'hA5, 1'b0});
    vecs.push_back('{1'b0, 4'd3,  8'h00, 16, 8'h00, 8'h00, 1'b1});
    vecs.push_back('{1'b1, 4'd5,  8'h77, 16, 8'h00, 8'h00, 1'b1});
    vecs.push_back('{1'b0, 4'd5,  8'h00, 0,  8'h00, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 4'd7,  8'h5A, 0,  8'h01, VFY ? 8'h5B : 8'h00, VFY});
    vecs.push_back('{1'b0, 4'd7,  8'h00, 2,  8'h00, 8'h5B, 1'b0});
    vecs.push_back('{1'b1, 4'd7,  8'h5A, 1,  8'h00, VFY ? 8'h5A : 8'h00, 1'b0});
    vecs.push_back('{1'b0, 4'd7,  8'h00, 0,  8'h00, 8'h5A, 1'b0});

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_ram_valid", ram_valid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_outputs", {rsp_err, ram_wr_rd, ram_addr, ram_wdata, rsp_rdata}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Directed table
    foreach (vecs[i]) begin
      ref_op(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].delay, vecs[i].corr, rd, er);
      do_cmd(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].delay, vecs[i].corr,
             vecs[i].e_rdata, vecs[i].e_err, 1'b0);
    end

    // Reset during a stalled read: no response, immediate reset values.
    ready_delay = 100;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd9;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midreq_ram_valid", ram_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_ram_valid", ram_valid, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_outputs", {rsp_err, ram_wr_rd, ram_addr, ram_wdata, rsp_rdata}, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("midrst_no_rsp", seen, 0);
    ref_op(1'b0, 4'd15, 8'h00, 0, 8'h00, rd, er);
    do_cmd(1'b0, 4'd15, 8'h00, 0, 8'h00, rd, er, 1'b0);

    // Back-to-back: cmd_valid held high, 16 writes then 16 reads.
    x0 = xfers;
    r0 = rises;
    for (int i = 0; i < 32; i++) begin
      logic [DATA_W-1:0] dat;
      dat = DATA_W'($urandom);
      ref_op(i < 16, ADDR_W'(i % 16), dat, 0, 8'h00, rd, er);
      do_cmd(i < 16, ADDR_W'(i % 16), dat, 0, 8'h00, rd, er, 1'b1);
    end
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("b2b_transfers", xfers - x0, VFY ? 48 : 32);
    check("b2b_valid_rises", rises - r0, VFY ? 48 : 32);

    // Randomized commands with ready noise outside transfers.
    noise_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bit wr;
      int r, d;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] dat, corr;
      wr  = 1'($urandom_range(0, 1));
      a   = ADDR_W'($urandom);
      dat = DATA_W'($urandom);
      r   = $urandom_range(0, 9);
      d   = (r < 7) ? $urandom_range(0, 3) : (r == 7) ? TMO - 1 : (r == 8) ? TMO : TMO + 3;
      corr = (VFY && $urandom_range(0, 3) == 0) ? DATA_W'($urandom_range(1, 255)) : '0;
      ref_op(wr, a, dat, d, corr, rd, er);
      do_cmd(wr, a, dat, d, corr, rd, er, 1'b0);
    end
    noise_en = 1'b0;

    repeat (3) @(negedge clk);
    check("ram_request_stable", stab_err, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_timeout: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "time limit");
  end

endmodule
